// File: rtl/pipe_mips32_pkg.sv
// pipe_mips32_pkg: opcodes, field slices, instruction classes
// and inter-stage bundles shared by the 5-stage MIPS32 core.
package pipe_mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_NOP   = 6'b111110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Bubble word: an unassigned opcode, decodes as NOP.
  localparam logic [31:0] NOP_IR = {OP_NOP, 26'd0};

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic [5:0]  op;
    instr_t      ty;
    logic [4:0]  dst;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    instr_t      ty;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    instr_t      ty;
    logic [4:0]  dst;
    logic [31:0] res;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{
    ir: NOP_IR, npc: 32'd0
  };

  localparam id_ex_t ID_EX_NOP = '{
    op: OP_NOP, ty: NOP, dst: 5'd0,
    npc: 32'd0, a: 32'd0, b: 32'd0,
    imm: 32'd0
  };

  localparam ex_mem_t EX_MEM_NOP = '{
    ty: NOP, dst: 5'd0,
    alu: 32'd0, b: 32'd0
  };

  localparam mem_wb_t MEM_WB_NOP = '{
    ty: NOP, dst: 5'd0, res: 32'd0
  };

  function automatic instr_t decode(
    input logic [5:0] op
  );
    instr_t t;
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT, OP_MUL:   t = RR_ALU;
      OP_ADDI, OP_SUBI,
      OP_SLTI:                 t = RM_ALU;
      OP_LW:                   t = LOAD;
      OP_SW:                   t = STORE;
      OP_BNEQZ, OP_BEQZ:       t = BRANCH;
      OP_HLT:                  t = HALT;
      default:                 t = NOP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_mips32_if.sv
// pipe_mips32_if: operand/result bundle between the EX stage
// (master: op, a, b) and the combinational ALU (slave: y).
interface pipe_mips32_if;

  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;

  modport master (
    output op,
    output a,
    output b,
    input  y
  );

  modport slave (
    input  op,
    input  a,
    input  b,
    output y
  );

endinterface

// File: rtl/pipe_mips32_alu.sv
// pipe_mips32_alu: combinational ALU, y = f(op, a, b).
// Ports: bus (slave) carries op/a/b in and y out.
module pipe_mips32_alu
  import pipe_mips32_pkg::*;
(
  pipe_mips32_if.slave bus
);

  logic w_add;
  logic w_sub;
  logic w_slt;

  // Loads, stores and branches use the adder for
  // address / target generation.
  assign w_add = (bus.op == OP_ADD)   ||
                 (bus.op == OP_ADDI)  ||
                 (bus.op == OP_LW)    ||
                 (bus.op == OP_SW)    ||
                 (bus.op == OP_BNEQZ) ||
                 (bus.op == OP_BEQZ);
  assign w_sub = (bus.op == OP_SUB) ||
                 (bus.op == OP_SUBI);
  assign w_slt = (bus.op == OP_SLT) ||
                 (bus.op == OP_SLTI);

  always_comb begin
    bus.y = 32'd0;
    unique case (1'b1)
      w_add:
        bus.y = bus.a + bus.b;
      w_sub:
        bus.y = bus.a - bus.b;
      (bus.op == OP_AND):
        bus.y = bus.a & bus.b;
      (bus.op == OP_OR):
        bus.y = bus.a | bus.b;
      w_slt:
        bus.y = {31'd0,
                 $signed(bus.a) < $signed(bus.b)};
      (bus.op == OP_MUL):
        bus.y = bus.a * bus.b;
      default:
        bus.y = 32'd0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// pipe_mips32: 5-stage in-order MIPS32 subset core with internal
// Reg/Mem. Ports: clk, rst (sync, active high), halted (sticky).
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  if_id_t  r_if_id;
  id_ex_t  r_id_ex;
  ex_mem_t r_ex_mem;
  mem_wb_t r_mem_wb;

  logic [5:0]    w_op;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_rd;
  logic [4:0]    w_dst;
  logic [31:0]   w_imm;
  logic [31:0]   w_a;
  logic [31:0]   w_b;
  instr_t        w_ty;
  logic          w_wb_we;
  logic          w_cond;
  logic          w_taken;
  logic          w_halt_fly;
  logic [AW-1:0] w_maddr;
  logic [31:0]   w_mem_res;

  pipe_mips32_if u_alu_bus ();

  pipe_mips32_alu u_alu (
    .bus (u_alu_bus)
  );

  assign halted = HALTED;

  // ID: field extraction and class decode
  assign w_op  = r_if_id.ir[OP_HI:OP_LO];
  assign w_rs  = r_if_id.ir[RS_HI:RS_LO];
  assign w_rt  = r_if_id.ir[RT_HI:RT_LO];
  assign w_rd  = r_if_id.ir[RD_HI:RD_LO];
  assign w_imm = {{16{r_if_id.ir[IMM_HI]}},
                  r_if_id.ir[IMM_HI:IMM_LO]};
  assign w_ty  = decode(w_op);

  always_comb begin
    w_dst = 5'd0;
    unique case (1'b1)
      (w_ty == RR_ALU):
        w_dst = w_rd;
      (w_ty == RM_ALU),
      (w_ty == LOAD):
        w_dst = w_rt;
      default:
        w_dst = 5'd0;
    endcase
  end

  // WB: only producers with a non-zero target write.
  assign w_wb_we = !rst && !HALTED &&
                   (r_mem_wb.dst != 5'd0) &&
                   ((r_mem_wb.ty == RR_ALU) ||
                    (r_mem_wb.ty == RM_ALU) ||
                    (r_mem_wb.ty == LOAD));

  // Register read with write-through from WB, which is
  // what makes a 2-instruction gap sufficient.
  always_comb begin
    w_a = (w_rs == 5'd0) ? 32'd0 : Reg[w_rs];
    w_b = (w_rt == 5'd0) ? 32'd0 : Reg[w_rt];
    if (w_wb_we && (r_mem_wb.dst == w_rs))
      w_a = r_mem_wb.res;
    if (w_wb_we && (r_mem_wb.dst == w_rt))
      w_b = r_mem_wb.res;
  end

  // EX: operand select; branches add imm to npc.
  assign u_alu_bus.op = r_id_ex.op;
  assign u_alu_bus.a  = (r_id_ex.ty == BRANCH) ?
                        r_id_ex.npc : r_id_ex.a;
  assign u_alu_bus.b  = (r_id_ex.ty == RR_ALU) ?
                        r_id_ex.b : r_id_ex.imm;

  assign w_cond  = (r_id_ex.op == OP_BEQZ) ?
                   (r_id_ex.a == 32'd0) :
                   (r_id_ex.a != 32'd0);
  assign w_taken = (r_id_ex.ty == BRANCH) &&
                   w_cond && !HALTED;

  // Once a HLT is anywhere in the pipe, fetch bubbles so
  // nothing younger than it can ever write.
  assign w_halt_fly = (w_ty == HALT)           ||
                      (r_id_ex.ty == HALT)     ||
                      (r_ex_mem.ty == HALT)    ||
                      (r_mem_wb.ty == HALT);

  // MEM
  assign w_maddr   = r_ex_mem.alu[AW-1:0];
  assign w_mem_res = (r_ex_mem.ty == LOAD) ?
                     Mem[w_maddr] : r_ex_mem.alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_if_id      <= IF_ID_NOP;
      r_id_ex      <= ID_EX_NOP;
      r_ex_mem     <= EX_MEM_NOP;
      r_mem_wb     <= MEM_WB_NOP;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      PC <= w_taken ? u_alu_bus.y : PC + 32'd1;

      if (w_taken || w_halt_fly)
        r_if_id <= IF_ID_NOP;
      else
        r_if_id <= '{ir:  Mem[PC[AW-1:0]],
                     npc: PC + 32'd1};

      if (w_taken)
        r_id_ex <= ID_EX_NOP;
      else
        r_id_ex <= '{op: w_op, ty: w_ty,
                     dst: w_dst,
                     npc: r_if_id.npc,
                     a: w_a, b: w_b,
                     imm: w_imm};

      r_ex_mem <= '{ty:  r_id_ex.ty,
                    dst: r_id_ex.dst,
                    alu: u_alu_bus.y,
                    b:   r_id_ex.b};

      r_mem_wb <= '{ty:  r_ex_mem.ty,
                    dst: r_ex_mem.dst,
                    res: w_mem_res};

      if (r_mem_wb.ty == HALT)
        HALTED <= 1'b1;
    end
  end

  // Architectural state: never reset, frozen when halted.
  always_ff @(posedge clk) begin
    if (!rst && !HALTED) begin
      if (r_ex_mem.ty == STORE)
        Mem[w_maddr] <= r_ex_mem.b;
      if (w_wb_we)
        Reg[r_mem_wb.dst] <= r_mem_wb.res;
    end
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: ALU vector table plus program runs with a
// scoreboard of expected register/memory results.
module tb_pipe_mips32;
  import pipe_mips32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;

  always #5 clk = ~clk;

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  pipe_mips32_if alu_bus ();

  pipe_mips32_alu u_alu (
    .bus (alu_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    string       name;
  } alu_vec_t;

  exp_t sb[$];

  localparam logic [31:0] HLT_IR = {OP_HLT, 26'd0};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(
    input logic [5:0] op, input int rd,
    input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(
    input logic [5:0] op, input int rt,
    input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic void exp_reg(
    input int r, input logic [31:0] v,
    input string n);
    sb.push_back('{1'b0, r, v, n});
  endfunction

  function automatic void exp_mem(
    input int a, input logic [31:0] v,
    input string n);
    sb.push_back('{1'b1, a, v, n});
  endfunction

  // Holds rst across one posedge; caller may poke more
  // state between begin_load and end_load.
  task automatic begin_load(input logic [31:0] p[$]);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++)
      dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++)
      dut.Reg[k] = 32'(k);
    for (int i = 0; i < p.size(); i++)
      dut.Mem[i] = p[i];
  endtask

  task automatic end_load(input string tag);
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rst_pc"}, dut.PC, 32'd0);
  endtask

  task automatic run(input int bound, input string tag,
                     output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    while (!halted && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (dut.TAKEN_BRANCH) pulses++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_halt: halted=0 after %0d cycles, required 1",
               tag, bound);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem)
        check(e.name, dut.Mem[e.idx], e.val);
      else
        check(e.name, dut.Reg[e.idx], e.val);
    end
  endtask

  initial begin
    alu_vec_t    v[16];
    logic [31:0] p[$];
    int          cyc;
    int          pulses;

    v[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,
              32'h0, "alu_add_wrap"};
    v[1]  = '{OP_ADDI, 32'd5, 32'hFFFF_FFFB,
              32'h0, "alu_addi_neg"};
    v[2]  = '{OP_SUB,  32'd3, 32'd5,
              32'hFFFF_FFFE, "alu_sub"};
    v[3]  = '{OP_SUBI, 32'd10, 32'd1,
              32'd9, "alu_subi"};
    v[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0,
              32'h00F0_00F0, "alu_and"};
    v[5]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0,
              32'hFFF0_FFF0, "alu_or"};
    v[6]  = '{OP_SLT,  32'hFFFF_FFFF, 32'd1,
              32'd1, "alu_slt_neg"};
    v[7]  = '{OP_SLT,  32'd1, 32'hFFFF_FFFF,
              32'd0, "alu_slt_pos"};
    v[8]  = '{OP_SLTI, 32'h8000_0000, 32'h7FFF_FFFF,
              32'd1, "alu_slti_min"};
    v[9]  = '{OP_SLTI, 32'd5, 32'd5,
              32'd0, "alu_slti_eq"};
    v[10] = '{OP_MUL,  32'd7, 32'd6,
              32'd42, "alu_mul"};
    v[11] = '{OP_MUL,  32'h0001_0001, 32'h0001_0001,
              32'h0002_0001, "alu_mul_low"};
    v[12] = '{OP_LW,   32'd200, 32'hFFFF_FFFE,
              32'd198, "alu_lw_addr"};
    v[13] = '{OP_BNEQZ, 32'd11, 32'hFFFF_FFFB,
              32'd6, "alu_br_target"};
    v[14] = '{OP_HLT,  32'd3, 32'd4,
              32'd0, "alu_hlt_zero"};
    v[15] = '{6'b010101, 32'd3, 32'd4,
              32'd0, "alu_undef_zero"};

    for (int i = 0; i < 16; i++) begin
      alu_bus.op = v[i].op;
      alu_bus.a  = v[i].a;
      alu_bus.b  = v[i].b;
      #1;
      check(v[i].name, alu_bus.y, v[i].y);
    end

    // Arithmetic chain with 2-slot spacing
    p = '{ri(OP_ADDI, 1, 0, 10), ri(OP_ADDI, 2, 0, 20),
          ri(OP_ADDI, 3, 0, 25), rr(OP_OR, 20, 20, 20),
          rr(OP_OR, 20, 20, 20), rr(OP_ADD, 4, 1, 2),
          rr(OP_OR, 20, 20, 20), rr(OP_OR, 20, 20, 20),
          rr(OP_ADD, 5, 4, 3), HLT_IR};
    begin_load(p);
    exp_reg(1, 32'd10, "p1_r1");
    exp_reg(2, 32'd20, "p1_r2");
    exp_reg(3, 32'd25, "p1_r3");
    exp_reg(4, 32'd30, "p1_r4");
    exp_reg(5, 32'd55, "p1_r5");
    exp_reg(0, 32'd0,  "p1_r0");
    exp_reg(20, 32'd20, "p1_r20");
    end_load("p1");
    run(100, "p1", cyc, pulses);
    check("p1_within_20", {31'd0, cyc <= 20}, 32'd1);
    check("p1_pc_frozen", dut.PC, 32'd14);
    drain();

    // Load, add, store
    p = '{ri(OP_LW, 2, 0, 120), NOP_IR, NOP_IR,
          ri(OP_ADDI, 2, 2, 45), NOP_IR, NOP_IR,
          ri(OP_SW, 2, 0, 121), HLT_IR};
    begin_load(p);
    dut.Mem[120] = 32'd85;
    exp_reg(2, 32'd130, "p2_r2");
    exp_mem(121, 32'd130, "p2_mem121");
    end_load("p2");
    run(100, "p2", cyc, pulses);
    drain();

    // Factorial of 7 with BNEQZ; slots 11/12 count
    // how often they execute.
    p = '{ri(OP_ADDI, 10, 0, 200), ri(OP_ADDI, 2, 0, 1),
          rr(OP_OR, 20, 20, 20), ri(OP_LW, 3, 10, 0),
          rr(OP_OR, 20, 20, 20), rr(OP_OR, 20, 20, 20),
          rr(OP_MUL, 2, 2, 3), ri(OP_SUBI, 3, 3, 1),
          rr(OP_OR, 20, 20, 20), rr(OP_OR, 20, 20, 20),
          ri(OP_BNEQZ, 0, 3, -5), ri(OP_ADDI, 7, 7, 1),
          ri(OP_ADDI, 8, 8, 1), ri(OP_SW, 2, 10, -2),
          HLT_IR};
    begin_load(p);
    dut.Mem[200] = 32'd7;
    exp_mem(198, 32'd5040, "p3_mem198");
    exp_reg(2, 32'd5040, "p3_r2");
    exp_reg(3, 32'd0, "p3_r3");
    exp_reg(7, 32'd8, "p3_slot1_once");
    exp_reg(8, 32'd9, "p3_slot2_once");
    end_load("p3");
    run(400, "p3", cyc, pulses);
    check("p3_taken_pulses", 32'(pulses), 32'd6);
    drain();

    // HLT freezes; younger SW and ADDI never write
    p = '{ri(OP_ADDI, 9, 0, 5), HLT_IR,
          ri(OP_SW, 6, 0, 300), ri(OP_ADDI, 6, 0, 99)};
    begin_load(p);
    dut.Mem[300] = 32'h0000_DEAD;
    exp_reg(9, 32'd5, "p4_older_r9");
    exp_reg(6, 32'd6, "p4_r6_kept");
    exp_mem(300, 32'h0000_DEAD, "p4_mem300_kept");
    end_load("p4");
    run(100, "p4", cyc, pulses);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("p4_pc_frozen", dut.PC, 32'd6);
      check("p4_halted_sticky", {31'd0, halted}, 32'd1);
    end
    drain();

    // Reset while instruction 0 is in WB
    p = '{ri(OP_ADDI, 11, 0, 111), ri(OP_ADDI, 12, 0, 122),
          ri(OP_ADDI, 13, 0, 133), rr(OP_OR, 20, 20, 20),
          rr(OP_OR, 20, 20, 20), HLT_IR};
    begin_load(p);
    end_load("p5");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("p5_mid_pc", dut.PC, 32'd0);
    check("p5_mid_halted", {31'd0, halted}, 32'd0);
    check("p5_mid_r11", dut.Reg[11], 32'd11);
    check("p5_mid_r12", dut.Reg[12], 32'd12);
    exp_reg(11, 32'd111, "p5_r11");
    exp_reg(12, 32'd122, "p5_r12");
    exp_reg(13, 32'd133, "p5_r13");
    run(100, "p5", cyc, pulses);
    drain();

    // No forwarding: second ADD sees stale R4 (=4)
    p = '{rr(OP_ADD, 4, 1, 2), rr(OP_ADD, 5, 4, 3),
          rr(OP_OR, 20, 20, 20), rr(OP_OR, 20, 20, 20),
          HLT_IR};
    begin_load(p);
    exp_reg(4, 32'd3, "p6_r4");
    exp_reg(5, 32'd7, "p6_r5_stale");
    end_load("p6");
    run(100, "p6", cyc, pulses);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
